reg_access_seq: RTL and testbench

- Sequencer between instruction decode and the single-port register file.
- Takes one request per instruction (two source reads, optional destination write) and serialises it onto the register file's port: W, ON, ADDR, DATA_IN out; DATA_OUT in.
- Returns both read operands to decode through a valid/ready response.
- Reads always happen before the write, so operands see pre-write values.

---
 rtl/reg_access_seq_if.sv | 39 +++
 rtl/reg_access_seq.sv | 159 +++++++++++++++
 tb/tb_reg_access_seq.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/reg_access_seq_if.sv
// reg_access_seq_if: bundles the decode request, operand response and
// register-file port of reg_access_seq.
//   master: decode / register-file side
//   slave : the sequencer
interface reg_access_seq_if #(
    parameter int unsigned WORD_SIZE = 16,
    parameter int unsigned ADDR_W    = 2
);
    logic                 REQ_VALID;
    logic                 REQ_READY;
    logic [ADDR_W-1:0]    REQ_RS;
    logic [ADDR_W-1:0]    REQ_RT;
    logic [ADDR_W-1:0]    REQ_RD;
    logic                 REQ_WE;
    logic [WORD_SIZE-1:0] REQ_WDATA;
    logic                 RSP_VALID;
    logic                 RSP_READY;
    logic [WORD_SIZE-1:0] RSP_A;
    logic [WORD_SIZE-1:0] RSP_B;
    logic                 REG_W;
    logic                 REG_ON;
    logic [WORD_SIZE-1:0] REG_ADDR;
    logic [WORD_SIZE-1:0] REG_DIN;
    logic [WORD_SIZE-1:0] REG_DOUT;

    modport master (
        output REQ_VALID, REQ_RS, REQ_RT, REQ_RD, REQ_WE, REQ_WDATA,
        output RSP_READY, REG_DOUT,
        input  REQ_READY, RSP_VALID, RSP_A, RSP_B,
        input  REG_W, REG_ON, REG_ADDR, REG_DIN
    );

    modport slave (
        input  REQ_VALID, REQ_RS, REQ_RT, REQ_RD, REQ_WE, REQ_WDATA,
        input  RSP_READY, REG_DOUT,
        output REQ_READY, RSP_VALID, RSP_A, RSP_B,
        output REG_W, REG_ON, REG_ADDR, REG_DIN
    );
endinterface

// File: rtl/reg_access_seq.sv
// reg_access_seq: serialises one decode request (read RS, read RT, optional
// write RD) onto a single-port register file and returns both operands
// through a valid/ready response. Reads precede the write, so operands
// always carry pre-write values.
// Optional: define REG_SKIP_ZERO_EN to make address 0 a hardwired zero
// register (reads return 0 without touching the port, writes are dropped).
module reg_access_seq #(
    parameter int unsigned WORD_SIZE = 16,
    parameter int unsigned ADDR_W    = 2
) (
    input  logic              CLK,
    input  logic              RST_N,
    reg_access_seq_if.slave   bus
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD_A = 3'd1,
        RD_B = 3'd2,
        WR   = 3'd3,
        RSP  = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic [ADDR_W-1:0]    rs_q, rs_d;
    logic [ADDR_W-1:0]    rt_q, rt_d;
    logic [ADDR_W-1:0]    rd_q, rd_d;
    logic                 we_q, we_d;
    logic [WORD_SIZE-1:0] wdata_q, wdata_d;
    logic [WORD_SIZE-1:0] rsp_a_q, rsp_a_d;
    logic [WORD_SIZE-1:0] rsp_b_q, rsp_b_d;

    logic                 req_ready;
    logic                 reg_w;
    logic                 reg_on;
    logic [WORD_SIZE-1:0] reg_addr;
    logic [WORD_SIZE-1:0] reg_din;

    // Gated by RST_N so decode never sees a ready while reset is held.
    assign req_ready = (state_q == IDLE) && RST_N;

    // State, latched request fields and captured operands.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            rs_q    <= '0;
            rt_q    <= '0;
            rd_q    <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            rsp_a_q <= '0;
            rsp_b_q <= '0;
        end else begin
            state_q <= state_d;
            rs_q    <= rs_d;
            rt_q    <= rt_d;
            rd_q    <= rd_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            rsp_a_q <= rsp_a_d;
            rsp_b_q <= rsp_b_d;
        end
    end

    // Next state: accept, two reads, optional write, then hold the response.
    always_comb begin
        state_d = state_q;
        rs_d    = rs_q;
        rt_d    = rt_q;
        rd_d    = rd_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        rsp_a_d = rsp_a_q;
        rsp_b_d = rsp_b_q;
        unique case (state_q)
            IDLE: begin
                if (bus.REQ_VALID && req_ready) begin
                    rs_d    = bus.REQ_RS;
                    rt_d    = bus.REQ_RT;
                    rd_d    = bus.REQ_RD;
                    we_d    = bus.REQ_WE;
                    wdata_d = bus.REQ_WDATA;
                    state_d = RD_A;
                end
            end
            RD_A: begin
                rsp_a_d = bus.REG_DOUT;
`ifdef REG_SKIP_ZERO_EN
                if (rs_q == '0) rsp_a_d = '0;
`endif
                state_d = RD_B;
            end
            RD_B: begin
                rsp_b_d = bus.REG_DOUT;
`ifdef REG_SKIP_ZERO_EN
                if (rt_q == '0) rsp_b_d = '0;
`endif
                state_d = we_q ? WR : RSP;
            end
            WR: begin
                state_d = RSP;
            end
            RSP: begin
                if (bus.RSP_READY) state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Register-file port, decoded from the state register only.
    always_comb begin
        reg_on   = 1'b0;
        reg_w    = 1'b0;
        reg_addr = '0;
        reg_din  = '0;
        unique case (state_q)
            RD_A: begin
                reg_on   = 1'b1;
                reg_addr = WORD_SIZE'(rs_q);
`ifdef REG_SKIP_ZERO_EN
                if (rs_q == '0) reg_on = 1'b0;
`endif
            end
            RD_B: begin
                reg_on   = 1'b1;
                reg_addr = WORD_SIZE'(rt_q);
`ifdef REG_SKIP_ZERO_EN
                if (rt_q == '0) reg_on = 1'b0;
`endif
            end
            WR: begin
                reg_on   = 1'b1;
                reg_w    = 1'b1;
                reg_addr = WORD_SIZE'(rd_q);
                reg_din  = wdata_q;
`ifdef REG_SKIP_ZERO_EN
                if (rd_q == '0) begin
                    reg_on = 1'b0;
                    reg_w  = 1'b0;
                end
`endif
            end
            default: begin
            end
        endcase
    end

    assign bus.REQ_READY = req_ready;
    assign bus.RSP_VALID = (state_q == RSP);
    assign bus.RSP_A     = rsp_a_q;
    assign bus.RSP_B     = rsp_b_q;
    assign bus.REG_W     = reg_w;
    assign bus.REG_ON    = reg_on;
    assign bus.REG_ADDR  = reg_addr;
    assign bus.REG_DIN   = reg_din;

endmodule

// File: tb/tb_reg_access_seq.sv
// tb_reg_access_seq: directed tests for reg_access_seq with a 4-entry
// register-file model. Expected values follow REG_SKIP_ZERO_EN when defined.
module tb_reg_access_seq;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    reg_access_seq_if #(.WORD_SIZE(16), .ADDR_W(2)) bus ();

    reg_access_seq #(.WORD_SIZE(16), .ADDR_W(2)) dut (
        .CLK   (clk),
        .RST_N (rst_n),
        .bus   (bus)
    );

    int unsigned vectors    = 0;
    int unsigned miscompares = 0;

    // Register-file model: combinational read, write at the posedge.
    logic [15:0] mem [0:3];
    logic        pl_we = 1'b0;
    logic [1:0]  pl_addr = '0;
    logic [15:0] pl_data = '0;

    always @(posedge clk) begin
        if (pl_we) mem[pl_addr] <= pl_data;
        else if (bus.REG_ON && bus.REG_W) mem[bus.REG_ADDR[1:0]] <= bus.REG_DIN;
    end

    // Filler outside reads; the sequencer must never capture it.
    assign bus.REG_DOUT = (bus.REG_ON && !bus.REG_W) ? mem[bus.REG_ADDR[1:0]] : 16'hDEAD;

    // Write-pulse monitor.
    int unsigned wcnt = 0;
    logic [15:0] w_addr = '0;
    logic [15:0] w_din  = '0;
    always @(negedge clk) begin
        if (bus.REG_W === 1'b1) begin
            wcnt   <= wcnt + 1;
            w_addr <= bus.REG_ADDR;
            w_din  <= bus.REG_DIN;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [1:0] a, input logic [15:0] d);
        pl_addr = a;
        pl_data = d;
        pl_we   = 1'b1;
        tick();
        pl_we   = 1'b0;
    endtask

    // Presents a request for one edge, then scrambles the fields.
    task automatic issue(input logic [1:0] rs, input logic [1:0] rt, input logic [1:0] rd,
                         input logic we, input logic [15:0] wd);
        bus.REQ_RS    = rs;
        bus.REQ_RT    = rt;
        bus.REQ_RD    = rd;
        bus.REQ_WE    = we;
        bus.REQ_WDATA = wd;
        bus.REQ_VALID = 1'b1;
        tick();
        bus.REQ_VALID = 1'b0;
        bus.REQ_RS    = ~rs;
        bus.REQ_RT    = ~rt;
        bus.REQ_RD    = ~rd;
        bus.REQ_WE    = ~we;
        bus.REQ_WDATA = ~wd;
    endtask

    task automatic test_reset;
        rst_n         = 1'b0;
        bus.REQ_VALID = 1'b1;
        bus.REQ_RS    = 2'd1;
        bus.REQ_RT    = 2'd2;
        bus.REQ_RD    = 2'd3;
        bus.REQ_WE    = 1'b1;
        bus.REQ_WDATA = 16'h5555;
        bus.RSP_READY = 1'b0;
        tick(); tick(); tick();
        vectors++; if (bus.REQ_READY !== 1'b0) begin miscompares++; $display("FAIL rst_req_ready: got %b want 0", bus.REQ_READY); end
        vectors++; if (bus.RSP_VALID !== 1'b0) begin miscompares++; $display("FAIL rst_rsp_valid: got %b want 0", bus.RSP_VALID); end
        vectors++; if ({bus.REG_W, bus.REG_ON} !== 2'b00) begin miscompares++; $display("FAIL rst_reg_ctl: got %b want 00", {bus.REG_W, bus.REG_ON}); end
        vectors++; if ({bus.REG_ADDR, bus.REG_DIN} !== 32'h0) begin miscompares++; $display("FAIL rst_reg_bus: got %h want 0", {bus.REG_ADDR, bus.REG_DIN}); end
        vectors++; if ({bus.RSP_A, bus.RSP_B} !== 32'h0) begin miscompares++; $display("FAIL rst_rsp_ab: got %h want 0", {bus.RSP_A, bus.RSP_B}); end
        bus.REQ_VALID = 1'b0;
        rst_n = 1'b1;
        #1;
        vectors++; if (bus.REQ_READY !== 1'b1) begin miscompares++; $display("FAIL rst_release_ready: got %b want 1", bus.REQ_READY); end
    endtask

    task automatic test_read;
        int unsigned w0;
        preload(2'd1, 16'h1234);
        preload(2'd2, 16'h00FF);
        bus.RSP_READY = 1'b1;
        w0 = wcnt;
        issue(2'd1, 2'd2, 2'd3, 1'b0, 16'h9999);
        vectors++; if ({bus.REG_ON, bus.REG_W, bus.REG_ADDR} !== {2'b10, 16'h0001}) begin miscompares++; $display("FAIL rd_a_port: got %b%b %h want 10 0001", bus.REG_ON, bus.REG_W, bus.REG_ADDR); end
        tick();
        vectors++; if ({bus.REG_ON, bus.REG_W, bus.REG_ADDR} !== {2'b10, 16'h0002}) begin miscompares++; $display("FAIL rd_b_port: got %b%b %h want 10 0002", bus.REG_ON, bus.REG_W, bus.REG_ADDR); end
        vectors++; if (bus.RSP_VALID !== 1'b0) begin miscompares++; $display("FAIL rd_early_valid: got %b want 0", bus.RSP_VALID); end
        tick();
        vectors++; if (bus.RSP_VALID !== 1'b1) begin miscompares++; $display("FAIL rd_valid_lat2: got %b want 1", bus.RSP_VALID); end
        vectors++; if (bus.RSP_A !== 16'h1234) begin miscompares++; $display("FAIL rd_rsp_a: got %h want 1234", bus.RSP_A); end
        vectors++; if (bus.RSP_B !== 16'h00FF) begin miscompares++; $display("FAIL rd_rsp_b: got %h want 00ff", bus.RSP_B); end
        vectors++; if ({bus.REQ_READY, bus.REG_ON} !== 2'b00) begin miscompares++; $display("FAIL rd_rsp_idle_port: got %b want 00", {bus.REQ_READY, bus.REG_ON}); end
        tick();
        vectors++; if ({bus.REQ_READY, bus.RSP_VALID} !== 2'b10) begin miscompares++; $display("FAIL rd_back_idle: got %b want 10", {bus.REQ_READY, bus.RSP_VALID}); end
        vectors++; if (wcnt !== w0) begin miscompares++; $display("FAIL rd_no_write: got %0d pulses want 0", wcnt - w0); end
    endtask

    task automatic test_write_hazard;
        int unsigned w0;
        preload(2'd3, 16'h0005);
        bus.RSP_READY = 1'b1;
        w0 = wcnt;
        issue(2'd3, 2'd3, 2'd3, 1'b1, 16'hBEEF);
        tick();
        tick();
        vectors++; if ({bus.REG_ON, bus.REG_W, bus.REG_ADDR, bus.REG_DIN} !== {2'b11, 16'h0003, 16'hBEEF}) begin miscompares++; $display("FAIL wr_port: got %b%b %h %h want 11 0003 beef", bus.REG_ON, bus.REG_W, bus.REG_ADDR, bus.REG_DIN); end
        vectors++; if (bus.RSP_VALID !== 1'b0) begin miscompares++; $display("FAIL wr_early_valid: got %b want 0", bus.RSP_VALID); end
        tick();
        vectors++; if (bus.RSP_VALID !== 1'b1) begin miscompares++; $display("FAIL wr_valid_lat3: got %b want 1", bus.RSP_VALID); end
        vectors++; if ({bus.RSP_A, bus.RSP_B} !== {16'h0005, 16'h0005}) begin miscompares++; $display("FAIL wr_old_operands: got %h %h want 0005 0005", bus.RSP_A, bus.RSP_B); end
        tick();
        vectors++; if (wcnt - w0 !== 1) begin miscompares++; $display("FAIL wr_pulse_count: got %0d want 1", wcnt - w0); end
        vectors++; if ({w_addr, w_din} !== {16'h0003, 16'hBEEF}) begin miscompares++; $display("FAIL wr_pulse_data: got %h %h want 0003 beef", w_addr, w_din); end
        issue(2'd3, 2'd2, 2'd1, 1'b0, 16'h0);
        tick();
        tick();
        vectors++; if ({bus.RSP_A, bus.RSP_B} !== {16'hBEEF, 16'h00FF}) begin miscompares++; $display("FAIL wr_next_sees_new: got %h %h want beef 00ff", bus.RSP_A, bus.RSP_B); end
        tick();
    endtask

    task automatic test_stall;
        bus.RSP_READY = 1'b0;
        issue(2'd1, 2'd2, 2'd0, 1'b0, 16'h0);
        tick();
        tick();
        bus.REQ_VALID = 1'b1;
        bus.REQ_RS    = 2'd3;
        bus.REQ_RT    = 2'd3;
        bus.REQ_WE    = 1'b1;
        for (int i = 0; i < 5; i++) begin
            vectors++;
            if ({bus.RSP_VALID, bus.REQ_READY, bus.RSP_A, bus.RSP_B} !== {2'b10, 16'h1234, 16'h00FF}) begin
                miscompares++;
                $display("FAIL stall_hold[%0d]: got %b%b %h %h want 10 1234 00ff", i, bus.RSP_VALID, bus.REQ_READY, bus.RSP_A, bus.RSP_B);
            end
            tick();
        end
        bus.REQ_VALID = 1'b0;
        bus.REQ_WE    = 1'b0;
        bus.RSP_READY = 1'b1;
        tick();
        vectors++; if ({bus.RSP_VALID, bus.REQ_READY, bus.REG_ON} !== 3'b010) begin miscompares++; $display("FAIL stall_release: got %b want 010", {bus.RSP_VALID, bus.REQ_READY, bus.REG_ON}); end
    endtask

    task automatic test_reset_mid_write;
        int unsigned w0;
        bus.RSP_READY = 1'b1;
        w0 = wcnt;
        issue(2'd1, 2'd1, 2'd2, 1'b1, 16'hAAAA);
        tick();
        tick();
        vectors++; if (bus.REG_W !== 1'b1) begin miscompares++; $display("FAIL rstwr_in_wr: got %b want 1", bus.REG_W); end
        #2;
        rst_n = 1'b0;
        #1;
        vectors++; if ({bus.REG_W, bus.REG_ON, bus.REQ_READY, bus.RSP_VALID} !== 4'b0000) begin miscompares++; $display("FAIL rstwr_drop: got %b want 0000", {bus.REG_W, bus.REG_ON, bus.REQ_READY, bus.RSP_VALID}); end
        vectors++; if ({bus.RSP_A, bus.RSP_B} !== 32'h0) begin miscompares++; $display("FAIL rstwr_rsp_clear: got %h %h want 0 0", bus.RSP_A, bus.RSP_B); end
        tick();
        vectors++; if (mem[2] !== 16'h00FF) begin miscompares++; $display("FAIL rstwr_reg2_kept: got %h want 00ff", mem[2]); end
        vectors++; if (wcnt !== w0) begin miscompares++; $display("FAIL rstwr_no_pulse: got %0d want 0", wcnt - w0); end
        rst_n = 1'b1;
        #1;
        vectors++; if (bus.REQ_READY !== 1'b1) begin miscompares++; $display("FAIL rstwr_ready_after: got %b want 1", bus.REQ_READY); end
    endtask

    task automatic test_zero_reg;
        logic        exp_on_a;
        logic [1:0]  exp_wr;
        logic [15:0] exp_a;
        logic [15:0] exp_r0;
`ifdef REG_SKIP_ZERO_EN
        exp_on_a = 1'b0; exp_wr = 2'b00; exp_a = 16'h0000; exp_r0 = 16'h7777;
`else
        exp_on_a = 1'b1; exp_wr = 2'b11; exp_a = 16'h7777; exp_r0 = 16'h1111;
`endif
        preload(2'd0, 16'h7777);
        bus.RSP_READY = 1'b1;
        issue(2'd0, 2'd1, 2'd0, 1'b1, 16'h1111);
        vectors++; if (bus.REG_ON !== exp_on_a) begin miscompares++; $display("FAIL zero_rd_a_on: got %b want %b", bus.REG_ON, exp_on_a); end
        tick();
        vectors++; if ({bus.REG_ON, bus.REG_ADDR} !== {1'b1, 16'h0001}) begin miscompares++; $display("FAIL zero_rd_b_port: got %b %h want 1 0001", bus.REG_ON, bus.REG_ADDR); end
        tick();
        vectors++; if ({bus.REG_ON, bus.REG_W} !== exp_wr) begin miscompares++; $display("FAIL zero_wr_ctl: got %b want %b", {bus.REG_ON, bus.REG_W}, exp_wr); end
        vectors++; if (bus.RSP_VALID !== 1'b0) begin miscompares++; $display("FAIL zero_early_valid: got %b want 0", bus.RSP_VALID); end
        tick();
        vectors++; if (bus.RSP_VALID !== 1'b1) begin miscompares++; $display("FAIL zero_valid_lat3: got %b want 1", bus.RSP_VALID); end
        vectors++; if ({bus.RSP_A, bus.RSP_B} !== {exp_a, 16'h1234}) begin miscompares++; $display("FAIL zero_operands: got %h %h want %h 1234", bus.RSP_A, bus.RSP_B, exp_a); end
        tick();
        vectors++; if (mem[0] !== exp_r0) begin miscompares++; $display("FAIL zero_reg0: got %h want %h", mem[0], exp_r0); end
    endtask

    initial begin
        test_reset();
        test_read();
        test_write_hazard();
        test_stall();
        test_reset_mid_write();
        test_zero_reg();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
